// File: rtl/knn_vote_reader.sv
// knn_vote_reader: walks sorter ranks, fetches neighbour labels, tallies votes and reports the majority class
module knn_vote_reader #(
  parameter int W = 32,
  parameter int HW_K = 10,
  parameter int N_CLASS = 4,
  parameter int LW = $clog2(N_CLASS),
  parameter int VW = $clog2(HW_K + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W/2-1:0]  k_cfg,
  output logic [W/2-1:0]  sel,
  input  logic [W/2-1:0]  idx_in,
  output logic            label_en,
  output logic [W/2-1:0]  label_addr,
  input  logic [LW:0]     label_rdata,
  output logic            busy,
  output logic            done,
  output logic [LW-1:0]   class_out,
  output logic [VW-1:0]   votes_out,
  output logic            err
);
  localparam int IW = W / 2;
  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, DECIDE, FINISH} state_t;
  state_t state, nxt;
  logic [IW-1:0] kk, k_clamp;
  logic [LW:0] cnt;
  logic vote_v, upd;
  logic [VW-1:0] votes [N_CLASS];
  logic [LW-1:0] best;
  logic [VW-1:0] bestv;
  assign k_clamp = k_cfg > IW'(HW_K) ? IW'(HW_K) : k_cfg;
  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign upd = votes[cnt[LW-1:0]] > bestv;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? (k_clamp == '0 ? DECIDE : SCAN) : IDLE;
      SCAN:    nxt = sel == kk - 1'b1 ? DRAIN : SCAN;
      DRAIN:   nxt = cnt == (LW+1)'(1) ? DECIDE : DRAIN;
      DECIDE:  nxt = cnt == (LW+1)'(N_CLASS - 1) ? FINISH : DECIDE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // Label memory read is issued one cycle after sel; its data is voted one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= '0;
      label_en <= 1'b0;
      label_addr <= '0;
      vote_v <= 1'b0;
      kk <= '0;
      cnt <= '0;
      best <= '0;
      bestv <= '0;
      class_out <= '0;
      votes_out <= '0;
      err <= 1'b0;
      for (int i = 0; i < N_CLASS; i++) votes[i] <= '0;
    end else begin
      label_en <= state == SCAN;
      vote_v <= label_en;
      cnt <= state != nxt ? '0 : cnt + 1'b1;
      if (state == SCAN) begin
        label_addr <= idx_in;
        if (nxt == SCAN) sel <= sel + 1'b1;
      end
      if (vote_v) begin
        if (label_rdata[LW]) err <= 1'b1;
        else votes[label_rdata[LW-1:0]] <= votes[label_rdata[LW-1:0]] + 1'b1;
      end
      if (state == DECIDE && upd) begin
        best <= cnt[LW-1:0];
        bestv <= votes[cnt[LW-1:0]];
      end
      if (state == DECIDE && nxt == FINISH) begin
        class_out <= upd ? cnt[LW-1:0] : best;
        votes_out <= upd ? votes[cnt[LW-1:0]] : bestv;
      end
      if (state == IDLE && start) begin
        kk <= k_clamp;
        sel <= '0;
        err <= 1'b0;
        best <= '0;
        bestv <= '0;
        for (int i = 0; i < N_CLASS; i++) votes[i] <= '0;
      end
    end
  end
endmodule
